// File: rtl/alu_bus_mdr_core.sv
// Datapath core of the mini CPU: one-hot priority bus multiplexer, 32-bit ALU and
// the Memory Data Register. Everything except mdr_q is combinational.

package alu_bus_mdr_pkg;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001,
    OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_DIV  = 5'b01111,
    OP_MUL  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

endpackage

module alu_bus_mdr_core
  import alu_bus_mdr_pkg::*;
(
  input  logic         clock,
  input  logic         clear,
  input  logic [511:0] gpr_data,
  input  logic [15:0]  gpr_out,
  input  logic [31:0]  hi_data,
  input  logic [31:0]  lo_data,
  input  logic [31:0]  zhigh_data,
  input  logic [31:0]  zlow_data,
  input  logic [31:0]  pc_data,
  input  logic [31:0]  inport_data,
  input  logic [31:0]  c_sign_ext,
  input  logic         HIout,
  input  logic         LOout,
  input  logic         Zhighout,
  input  logic         Zlowout,
  input  logic         PCout,
  input  logic         InPortout,
  input  logic         Cout,
  input  logic         MDRout,
  input  logic         MDRin,
  input  logic         Read,
  input  logic [31:0]  mem_data_in,
  input  logic [31:0]  y_data,
  input  logic [4:0]   op,
  output logic [31:0]  BusMuxOut,
  output logic [31:0]  mdr_q,
  output logic [31:0]  z_low,
  output logic [31:0]  z_high
);

  // ---------------------------------------------------------------------------
  // Bus multiplexer
  // ---------------------------------------------------------------------------
  // Sources are visited from lowest to highest priority so the last match wins,
  // which leaves R0 as the strongest driver when several selects collide.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned and infers a latch.
    BusMuxOut = '0;
    if (Cout)      BusMuxOut = c_sign_ext;
    if (InPortout) BusMuxOut = inport_data;
    if (MDRout)    BusMuxOut = mdr_q;
    if (PCout)     BusMuxOut = pc_data;
    if (Zlowout)   BusMuxOut = zlow_data;
    if (Zhighout)  BusMuxOut = zhigh_data;
    if (LOout)     BusMuxOut = lo_data;
    if (HIout)     BusMuxOut = hi_data;
    for (int i = 15; i >= 0; i--) begin
      if (gpr_out[i]) BusMuxOut = gpr_data[32*i +: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // Memory Data Register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the bus, including its own mdr_q on a self-reload.
  // NOTE: mdr_q is the only storage in this block, so it alone is reset.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mdr_q <= '0;
    end else if (MDRin) begin
      mdr_q <= Read ? mem_data_in : BusMuxOut;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] a, b;
  logic [4:0]  shamt;

  assign a     = y_data;
  assign b     = BusMuxOut;
  assign shamt = b[4:0];

  // Signed divide on magnitudes: keeps -2^31 / -1 well defined (wraps to
  // 0x80000000, remainder 0) and avoids a divide-by-zero in the datapath.
  logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;

  always_comb begin
    a_mag = a[31] ? (32'd0 - a) : a;
    b_mag = b[31] ? (32'd0 - b) : b;
    q_mag = '0;
    r_mag = a_mag;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    div_q = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    div_r = a[31] ? (32'd0 - r_mag) : r_mag;
  end

  logic signed [63:0] product;
  assign product = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // Rotates: (0 - shamt) mod 32 is the complementary shift; shamt = 0 yields a|a.
  logic [31:0] ror_res, rol_res;
  assign ror_res = (a >> shamt) | (a << (5'd0 - shamt));
  assign rol_res = (a << shamt) | (a >> (5'd0 - shamt));

  always_comb begin
    z_low  = a + b;
    z_high = '0;
    case (alu_op_e'(op))
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: z_low = a + b;
      OP_SUB:          z_low = a - b;
      OP_AND, OP_ANDI: z_low = a & b;
      OP_OR,  OP_ORI:  z_low = a | b;
      OP_ROR:          z_low = ror_res;
      OP_ROL:          z_low = rol_res;
      OP_SHR:          z_low = a >> shamt;
      OP_SHRA:         z_low = 32'($signed(a) >>> shamt);
      OP_SHL:          z_low = a << shamt;
      OP_DIV: begin
        z_low  = div_q;
        z_high = div_r;
      end
      OP_MUL: begin
        z_low  = product[31:0];
        z_high = product[63:32];
      end
      OP_NEG:          z_low = 32'd0 - b;
      OP_NOT:          z_low = ~b;
      // br, jr, jal, in, out, mfhi, mflo, nop, halt and unused codes add;
      // br relies on this to form PC + C.
      default:         z_low = a + b;
    endcase
  end

endmodule

// File: tb/tb_alu_bus_mdr_core.sv
// Self-checking bench for alu_bus_mdr_core: directed cases from the datapath's
// documented behaviour, then randomized traffic against a behavioural model.

module tb_alu_bus_mdr_core;

  logic         clock = 1'b0;
  logic         clear;
  logic [511:0] gpr_data;
  logic [15:0]  gpr_out;
  logic [31:0]  hi_data, lo_data, zhigh_data, zlow_data, pc_data, inport_data, c_sign_ext;
  logic         HIout, LOout, Zhighout, Zlowout, PCout, InPortout, Cout, MDRout;
  logic         MDRin, Read;
  logic [31:0]  mem_data_in, y_data;
  logic [4:0]   op;
  logic [31:0]  BusMuxOut, mdr_q, z_low, z_high;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_mdr;

  alu_bus_mdr_core dut (
    .clock(clock), .clear(clear), .gpr_data(gpr_data), .gpr_out(gpr_out),
    .hi_data(hi_data), .lo_data(lo_data), .zhigh_data(zhigh_data), .zlow_data(zlow_data),
    .pc_data(pc_data), .inport_data(inport_data), .c_sign_ext(c_sign_ext),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
    .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout), .MDRin(MDRin), .Read(Read),
    .mem_data_in(mem_data_in), .y_data(y_data), .op(op),
    .BusMuxOut(BusMuxOut), .mdr_q(mdr_q), .z_low(z_low), .z_high(z_high)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_sel();
    gpr_out = '0;
    {HIout, LOout, Zhighout, Zlowout, PCout, InPortout, Cout, MDRout} = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] set_r(input int i, input logic [31:0] v);
    gpr_data[32*i +: 32] = v;
    return v;
  endfunction

  // Bus model: sources listed in priority order; the first asserted one drives.
  function automatic logic [31:0] bus_model();
    logic [31:0] src [24];
    logic        sel [24];
    for (int i = 0; i < 16; i++) begin
      src[i] = gpr_data[32*i +: 32];
      sel[i] = gpr_out[i];
    end
    src[16] = hi_data;     sel[16] = HIout;
    src[17] = lo_data;     sel[17] = LOout;
    src[18] = zhigh_data;  sel[18] = Zhighout;
    src[19] = zlow_data;   sel[19] = Zlowout;
    src[20] = pc_data;     sel[20] = PCout;
    src[21] = exp_mdr;     sel[21] = MDRout;
    src[22] = inport_data; sel[22] = InPortout;
    src[23] = c_sign_ext;  sel[23] = Cout;
    for (int i = 0; i < 24; i++) if (sel[i]) return src[i];
    return 32'd0;
  endfunction

  // ALU model: 64-bit integer arithmetic and bit-at-a-time shifting.
  task automatic alu_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] code,
                           output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, q, r, p;
    logic [31:0] t;
    int n;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    n  = int'(b[4:0]);
    t  = a;
    hi = 32'd0;
    case (int'(code))
      4:       lo = a - b;
      5, 13:   lo = a & b;
      6, 14:   lo = a | b;
      7:  begin repeat (n) t = {t[0], t[31:1]};     lo = t; end
      8:  begin repeat (n) t = {t[30:0], t[31]};    lo = t; end
      9:  begin repeat (n) t = {1'b0, t[31:1]};     lo = t; end
      10: begin repeat (n) t = {t[31], t[31:1]};    lo = t; end
      11: begin repeat (n) t = {t[30:0], 1'b0};     lo = t; end
      15: begin
        if (sb == 0) begin
          lo = 32'd0;
          hi = a;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      16: begin
        p  = sa * sb;
        lo = p[31:0];
        hi = p[63:32];
      end
      17:      lo = -b;
      18:      lo = ~b;
      default: lo = a + b;
    endcase
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] e_lo, e_hi, junk;

  initial begin
    clear = 1'b1;
    gpr_data = '0;
    {hi_data, lo_data, zhigh_data, zlow_data, pc_data, inport_data, c_sign_ext} = '0;
    clear_sel();
    MDRin = 1'b0; Read = 1'b0; mem_data_in = '0; y_data = '0; op = '0;
    exp_mdr = '0;
    #2;
    check("reset_mdr", mdr_q, 32'd0);
    step();
    clear = 1'b0;

    // Priority and idle bus
    junk = set_r(3, 32'h11);
    pc_data = 32'h22;
    gpr_out[3] = 1'b1; PCout = 1'b1;
    #1 check("prio_r3_pc", BusMuxOut, 32'h11);
    clear_sel();
    #1 check("bus_idle", BusMuxOut, 32'h0);

    // Add / sub
    y_data = 32'h7FFF_FFFF; junk = set_r(1, 32'd1); gpr_out[1] = 1'b1;
    op = 5'b00011;
    #1 check("add_lo", z_low, 32'h8000_0000);
    check("add_hi", z_high, 32'h0);
    op = 5'b00100;
    #1 check("sub_lo", z_low, 32'h7FFF_FFFE);

    // Mul / div
    y_data = 32'hFFFF_FFFD; junk = set_r(1, 32'd7); op = 5'b10000;
    #1 check("mul_hi", z_high, 32'hFFFF_FFFF);
    check("mul_lo", z_low, 32'hFFFF_FFEB);
    y_data = 32'hFFFF_FFF9; junk = set_r(1, 32'd2); op = 5'b01111;
    #1 check("div_lo", z_low, 32'hFFFF_FFFD);
    check("div_hi", z_high, 32'hFFFF_FFFF);
    junk = set_r(1, 32'd0);
    #1 check("div0_lo", z_low, 32'h0);
    check("div0_hi", z_high, 32'hFFFF_FFF9);

    // Shifts and rotates
    y_data = 32'h8000_0001; junk = set_r(1, 32'd4);
    op = 5'b00111; #1 check("ror", z_low, 32'h1800_0000);
    op = 5'b01000; #1 check("rol", z_low, 32'h0000_0018);
    op = 5'b01001; #1 check("shr", z_low, 32'h0800_0000);
    op = 5'b01010; #1 check("shra", z_low, 32'hF800_0000);
    op = 5'b01011; #1 check("shl", z_low, 32'h0000_0010);

    // MDR load from memory, readback, load from bus, self-reload
    clear_sel();
    MDRin = 1'b1; Read = 1'b1; mem_data_in = 32'hDEAD_BEEF;
    step();
    check("mdr_mem", mdr_q, 32'hDEAD_BEEF);
    MDRin = 1'b0; MDRout = 1'b1;
    #1 check("mdr_bus", BusMuxOut, 32'hDEAD_BEEF);
    MDRout = 1'b0; Cout = 1'b1; c_sign_ext = 32'h5; Read = 1'b0; MDRin = 1'b1;
    step();
    check("mdr_from_bus", mdr_q, 32'h5);
    Cout = 1'b0; MDRout = 1'b1;
    #1 check("mdr_self_bus", BusMuxOut, 32'h5);
    step();
    check("mdr_self_load", mdr_q, 32'h5);

    // Asynchronous clear, with priority over MDRin
    MDRin = 1'b0; MDRout = 1'b0;
    #2 clear = 1'b1;
    #1 check("clear_async", mdr_q, 32'h0);
    MDRin = 1'b1; Read = 1'b1; mem_data_in = 32'h1234_5678;
    step();
    check("clear_hold", mdr_q, 32'h0);
    clear = 1'b0;
    MDRin = 1'b0;
    exp_mdr = '0;

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < 16; i++) junk = set_r(i, rand_val());
      hi_data = rand_val(); lo_data = rand_val(); zhigh_data = rand_val();
      zlow_data = rand_val(); pc_data = rand_val(); inport_data = rand_val();
      c_sign_ext = rand_val();
      clear_sel();
      if ($urandom_range(0, 4) != 0) begin
        for (int i = 0; i < 16; i++) gpr_out[i] = ($urandom_range(0, 15) == 0);
        HIout = ($urandom_range(0, 7) == 0);  LOout = ($urandom_range(0, 7) == 0);
        Zhighout = ($urandom_range(0, 7) == 0); Zlowout = ($urandom_range(0, 7) == 0);
        PCout = ($urandom_range(0, 7) == 0);  MDRout = ($urandom_range(0, 3) == 0);
        InPortout = ($urandom_range(0, 3) == 0); Cout = ($urandom_range(0, 2) == 0);
      end
      y_data = rand_val();
      op = 5'($urandom_range(0, 31));
      MDRin = $urandom_range(0, 1) == 1;
      Read = $urandom_range(0, 1) == 1;
      mem_data_in = $urandom();
      #1;
      check("rnd_bus", BusMuxOut, bus_model());
      alu_model(y_data, bus_model(), op, e_lo, e_hi);
      check("rnd_zlow", z_low, e_lo);
      check("rnd_zhigh", z_high, e_hi);
      check("rnd_mdr", mdr_q, exp_mdr);
      if ($urandom_range(0, 19) == 0) begin
        clear = 1'b1;
        exp_mdr = '0;
        #1 check("rnd_clear", mdr_q, 32'h0);
      end
      if (!clear && MDRin) exp_mdr = Read ? mem_data_in : bus_model();
      step();
      clear = 1'b0;
    end
    #1 check("final_mdr", mdr_q, exp_mdr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
